// File: rtl/fpu_uart_pkg.sv
//==============================================================================
// Package  : fpu_uart_pkg
// Brief    : Shared constants and state encoding for the FPU result UART TX path.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package fpu_uart_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    START = ST_START,
    DATA  = ST_DATA,
    STOP  = ST_STOP,
    DONE  = ST_DONE
  } tx_state_t;

  localparam logic        UART_IDLE_LEVEL  = 1'b1;
  localparam int          BYTES_PER_WORD   = 2;
  localparam logic [15:0] MIN_CLKS_PER_BIT = 16'd2;

  // A bit period below two clocks cannot be counted reliably, so clamp it.
  function automatic logic [15:0] eff_period(input logic [15:0] cpb);
    return (cpb < MIN_CLKS_PER_BIT) ? MIN_CLKS_PER_BIT : cpb;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fpu_result_uart_tx_if.sv
//==============================================================================
// Interface : fpu_result_uart_tx_if
// Brief     : FPU result strobe/data bundle feeding the UART transmitter.
// Revision  : 1.0 - initial release
//==============================================================================
`default_nettype none

interface fpu_result_uart_tx_if #(
  parameter int DATA_W = 16
);
  logic              res_valid;
  logic [DATA_W-1:0] res_data;

  modport master (output res_valid, output res_data);
  modport slave  (input  res_valid, input  res_data);
endinterface

`default_nettype wire

// File: rtl/fpu_uart_tx_fifo.sv
//==============================================================================
// Module   : fpu_uart_tx_fifo
// Brief    : Synchronous FIFO with extra-MSB pointers for full/empty detection.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module fpu_uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  wire logic             clk,
  input  wire logic             rst_l,
  input  wire logic             push,
  input  wire logic [WIDTH-1:0] wr_data,
  input  wire logic             pop,
  output logic      [WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
  end

  // Read is combinational so a pop while full still sees the old head entry.
  assign rd_data = r_mem[r_rd_ptr[AW-1:0]];
  assign empty   = (r_wr_ptr == r_rd_ptr);
  assign full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

endmodule

`default_nettype wire

// File: rtl/fpu_result_uart_tx.sv
//==============================================================================
// Module   : fpu_result_uart_tx
// Brief    : Buffers FPU results and sends each as two 8N1 frames, low byte first.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module fpu_result_uart_tx
  import fpu_uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = 16
) (
  input  wire logic                 clk,
  input  wire logic                 rst_l,
  input  wire logic [15:0]          clks_per_bit,
  input  wire logic                 tx_enable,
  fpu_result_uart_tx_if.slave       res,
  output logic                      o_Tx_Serial,
  output logic                      o_Tx_Active,
  output logic                      o_Tx_Done,
  output logic                      fifo_full,
  output logic                      overflow
);

  tx_state_t         r_state, w_state_nxt;
  logic [15:0]       r_period, w_period_nxt;
  logic [15:0]       r_clk_cnt, w_clk_cnt_nxt;
  logic [2:0]        r_bit_idx, w_bit_idx_nxt;
  logic              r_byte_sel, w_byte_sel_nxt;
  logic [DATA_W-1:0] r_word, w_word_nxt;
  logic              r_overflow;

  logic              w_pop, w_push, w_empty, w_full, w_bit_end;
  logic [DATA_W-1:0] w_fifo_rd;
  logic [7:0]        w_cur_byte;

  assign w_push = res.res_valid && (!w_full || w_pop);

  fpu_uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst_l   (rst_l),
    .push    (w_push),
    .wr_data (res.res_data),
    .pop     (w_pop),
    .rd_data (w_fifo_rd),
    .full    (w_full),
    .empty   (w_empty)
  );

  assign w_bit_end  = (r_clk_cnt == (r_period - 16'd1));
  assign w_cur_byte = r_byte_sel ? r_word[15:8] : r_word[7:0];

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_state    <= IDLE;
      r_period   <= MIN_CLKS_PER_BIT;
      r_clk_cnt  <= '0;
      r_bit_idx  <= '0;
      r_byte_sel <= 1'b0;
      r_word     <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_period   <= w_period_nxt;
      r_clk_cnt  <= w_clk_cnt_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_byte_sel <= w_byte_sel_nxt;
      r_word     <= w_word_nxt;
      if (res.res_valid && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_period_nxt   = r_period;
    w_clk_cnt_nxt  = r_clk_cnt;
    w_bit_idx_nxt  = r_bit_idx;
    w_byte_sel_nxt = r_byte_sel;
    w_word_nxt     = r_word;
    w_pop          = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty && tx_enable) begin
          w_pop          = 1'b1;
          w_word_nxt     = w_fifo_rd;
          w_byte_sel_nxt = 1'b0;
          w_period_nxt   = eff_period(clks_per_bit);
          w_clk_cnt_nxt  = '0;
          w_state_nxt    = START;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_clk_cnt_nxt = '0;
          w_bit_idx_nxt = '0;
          w_state_nxt   = DATA;
        end else begin
          w_clk_cnt_nxt = r_clk_cnt + 16'd1;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_clk_cnt_nxt = '0;
          if (r_bit_idx == 3'd7) w_state_nxt   = STOP;
          else                   w_bit_idx_nxt = r_bit_idx + 3'd1;
        end else begin
          w_clk_cnt_nxt = r_clk_cnt + 16'd1;
        end
      end
      STOP: begin
        if (w_bit_end) begin
          w_clk_cnt_nxt = '0;
          if (r_byte_sel == 1'(BYTES_PER_WORD - 1)) begin
            w_state_nxt = DONE;
          end else begin
            // High byte follows immediately, with the bit period resampled.
            w_byte_sel_nxt = 1'b1;
            w_period_nxt   = eff_period(clks_per_bit);
            w_state_nxt    = START;
          end
        end else begin
          w_clk_cnt_nxt = r_clk_cnt + 16'd1;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_Tx_Serial = UART_IDLE_LEVEL;
    case (r_state)
      START:   o_Tx_Serial = 1'b0;
      DATA:    o_Tx_Serial = w_cur_byte[r_bit_idx];
      default: o_Tx_Serial = UART_IDLE_LEVEL;
    endcase
  end

  assign o_Tx_Active = (r_state == START) || (r_state == DATA) || (r_state == STOP);
  assign o_Tx_Done   = (r_state == DONE);
  assign fifo_full   = w_full;
  assign overflow    = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_fpu_result_uart_tx.sv
//==============================================================================
// Module   : tb_fpu_result_uart_tx
// Brief    : Directed self-checking bench for the FPU result UART transmitter.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_fpu_result_uart_tx;

  logic        clk = 1'b0;
  logic        rst_l;
  logic [15:0] clks_per_bit;
  logic        tx_enable;
  logic        o_Tx_Serial, o_Tx_Active, o_Tx_Done, fifo_full, overflow;

  int n_cmp = 0;
  int n_err = 0;

  fpu_result_uart_tx_if #(.DATA_W(16)) res_if ();

  fpu_result_uart_tx #(
    .FIFO_DEPTH (4),
    .DATA_W     (16)
  ) dut (
    .clk          (clk),
    .rst_l        (rst_l),
    .clks_per_bit (clks_per_bit),
    .tx_enable    (tx_enable),
    .res          (res_if.slave),
    .o_Tx_Serial  (o_Tx_Serial),
    .o_Tx_Active  (o_Tx_Active),
    .o_Tx_Done    (o_Tx_Done),
    .fifo_full    (fifo_full),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int eff(input logic [15:0] c);
    return (c < 16'd2) ? 2 : int'(c);
  endfunction

  task automatic push_word(input logic [15:0] w);
    @(negedge clk);
    res_if.res_valid = 1'b1;
    res_if.res_data  = w;
    @(negedge clk);
    res_if.res_valid = 1'b0;
  endtask

  task automatic wait_start(output int waited);
    waited = -1;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (o_Tx_Serial === 1'b0) begin
        waited = i;
        break;
      end
    end
  endtask

  // Entered on the negedge where the first start-bit cycle is visible.
  task automatic check_word(input string tag, input logic [15:0] w, input int drop_at,
                            input int cpb_at, input logic [15:0] cpb_new);
    int   p, p_lo, p_hi, k, errs;
    logic [7:0] bv;
    logic exp_line;
    p_lo = eff(clks_per_bit);
    p_hi = (cpb_at >= 0) ? eff(cpb_new) : p_lo;
    errs = 0;
    k    = 0;
    for (int b = 0; b < 2; b++) begin
      p  = (b == 0) ? p_lo : p_hi;
      bv = (b == 0) ? w[7:0] : w[15:8];
      for (int pos = 0; pos < 10; pos++) begin
        exp_line = (pos == 0) ? 1'b0 : (pos == 9) ? 1'b1 : bv[pos-1];
        for (int c = 0; c < p; c++) begin
          if (k > 0) @(negedge clk);
          if (o_Tx_Serial !== exp_line || o_Tx_Active !== 1'b1 || o_Tx_Done !== 1'b0) errs++;
          if (k == drop_at) tx_enable = 1'b0;
          if (k == cpb_at)  clks_per_bit = cpb_new;
          k++;
        end
      end
    end
    check_val({tag, "_line"}, errs, 0);
    @(negedge clk);
    check_val({tag, "_done"}, {29'd0, o_Tx_Done, o_Tx_Active, o_Tx_Serial}, 32'b101);
  endtask

  task automatic count_lows(input int n, output int lows);
    lows = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (o_Tx_Serial !== 1'b1) lows++;
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int wt, lows, saw_full;
    rst_l            = 1'b0;
    clks_per_bit     = 16'd4;
    tx_enable        = 1'b0;
    res_if.res_valid = 1'b0;
    res_if.res_data  = 16'h0000;
    repeat (3) @(negedge clk);
    check_val("reset_outputs", {27'd0, o_Tx_Serial, o_Tx_Active, o_Tx_Done, fifo_full, overflow},
              32'b10000);
    rst_l = 1'b1;

    // Single word 0x3C00 at 4 clocks per bit
    tx_enable = 1'b1;
    push_word(16'h3C00);
    wait_start(wt);
    check_val("single_start_lat", wt, 1);
    check_word("single", 16'h3C00, -1, -1, 16'd0);

    // Bit period clamping and mid-word period change
    clks_per_bit = 16'd0;
    push_word(16'h1234);
    wait_start(wt);
    check_word("cpb0", 16'h1234, -1, -1, 16'd0);
    clks_per_bit = 16'd1;
    push_word(16'hA55A);
    wait_start(wt);
    check_word("cpb1", 16'hA55A, -1, -1, 16'd0);
    clks_per_bit = 16'd4;
    push_word(16'h0F81);
    wait_start(wt);
    check_word("cpb4to6", 16'h0F81, -1, 12, 16'd6);

    // Back-to-back words at 8 clocks per bit
    clks_per_bit = 16'd8;
    tx_enable    = 1'b0;
    push_word(16'hC0DE);
    push_word(16'h7E01);
    tx_enable = 1'b1;
    wait_start(wt);
    check_word("b2b_w1", 16'hC0DE, -1, -1, 16'd0);
    wait_start(wt);
    check_val("b2b_gap", wt, 2);
    check_word("b2b_w2", 16'h7E01, -1, -1, 16'd0);

    // tx_enable dropped during word 1 data phase
    clks_per_bit = 16'd4;
    tx_enable    = 1'b0;
    push_word(16'h55AA);
    push_word(16'h8001);
    tx_enable = 1'b1;
    wait_start(wt);
    check_word("gate_w1", 16'h55AA, 15, -1, 16'd0);
    count_lows(10, lows);
    check_val("gate_hold_high", lows, 0);
    tx_enable = 1'b1;
    wait_start(wt);
    check_val("gate_restart_lat", wt, 1);
    check_word("gate_w2", 16'h8001, -1, -1, 16'd0);

    // Burst of six pushes into a four-deep FIFO
    clks_per_bit = 16'd2;
    check_val("burst_pre_ovf", {31'd0, overflow}, 0);
    saw_full = 0;
    fork
      begin
        for (int i = 1; i <= 6; i++) begin
          @(negedge clk);
          if (fifo_full === 1'b1) saw_full = 1;
          res_if.res_valid = 1'b1;
          res_if.res_data  = 16'(i);
        end
        @(negedge clk);
        res_if.res_valid = 1'b0;
        check_val("burst_full_seen", saw_full, 1);
        check_val("burst_overflow", {31'd0, overflow}, 1);
      end
      begin
        for (int j = 1; j <= 5; j++) begin
          wait_start(wt);
          check_val((j == 1) ? "burst_first_lat" : "burst_gap", wt, (j == 1) ? 3 : 2);
          check_word($sformatf("burst_w%0d", j), 16'(j), -1, -1, 16'd0);
        end
        count_lows(30, lows);
        check_val("burst_w6_dropped", lows, 0);
        check_val("burst_ovf_sticky", {31'd0, overflow}, 1);
      end
    join

    // Reset asserted mid-frame with a second word still queued
    clks_per_bit = 16'd4;
    tx_enable    = 1'b0;
    push_word(16'hFFFF);
    push_word(16'h0000);
    tx_enable = 1'b1;
    wait_start(wt);
    repeat (6) @(negedge clk);
    #2 rst_l = 1'b0;
    #1 check_val("rst_async_line", {30'd0, o_Tx_Active, o_Tx_Serial}, 32'b01);
    @(negedge clk);
    @(negedge clk);
    rst_l = 1'b1;
    check_val("rst_flags", {29'd0, fifo_full, overflow, o_Tx_Done}, 0);
    count_lows(12, lows);
    check_val("rst_fifo_empty", lows, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
